// File: rtl/bar_command_gen.sv
// Paddle-bar move command generator.
// It synchronizes and debounces the up/down buttons, then clamps each move so
// the bar stays inside its limits. It issues a one-cycle custom-instruction
// strobe and waits for the bar position to follow, and it auto-repeats while
// the button is held.
module bar_command_gen #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SETTLE_CYCLES   = 1100000,
  parameter int STEP            = 10,
  parameter int Y_MIN           = 6,
  parameter int Y_MAX           = 472,
  parameter int BAR_H           = 89
) (
  input  logic       clk_in,
  input  logic       i_rst,
  input  logic       enablePong,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [8:0] y_Atual,
  output logic       clk_en,
  output logic       refreshBar,
  output logic       incDec,
  output logic [8:0] coordY,
  output logic       busy
);

  // One counter serves both the debounce and the settle phases.
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [9:0] Y_MIN_W = 10'(Y_MIN);
  localparam logic [9:0] Y_MAX_W = 10'(Y_MAX);
  localparam logic [9:0] BAR_H_W = 10'(BAR_H);
  localparam logic [9:0] STEP_W  = 10'(STEP);
  localparam logic [8:0] STEP_9  = 9'(STEP);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    CHECK    = 3'd2,
    ISSUE    = 3'd3,
    SETTLE   = 3'd4
  } state_t;

  state_t           state_q;
  logic             up_sync1_q, up_sync2_q;
  logic             dn_sync1_q, dn_sync2_q;
  logic             dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       target_q;
  logic             clk_en_q, refresh_q, incdec_q, busy_q;
  logic [8:0]       coordy_q;

  logic             held_alone_s;
  logic [9:0]       y_w_s;
  logic [9:0]       sum_s;
  logic [9:0]       room_s;
  logic [8:0]       step_s;
  logic [9:0]       target_s;

  assign y_w_s = {1'b0, y_Atual};

  // Two-flop synchronizers for the raw asynchronous buttons.
  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      up_sync1_q <= 1'b0;
      up_sync2_q <= 1'b0;
      dn_sync1_q <= 1'b0;
      dn_sync2_q <= 1'b0;
    end else begin
      up_sync1_q <= btn_up;
      up_sync2_q <= up_sync1_q;
      dn_sync1_q <= btn_down;
      dn_sync2_q <= dn_sync1_q;
    end
  end

  // Latched button is pressed on its own; this keeps debounce and auto-repeat going.
  always_comb begin
    if (dir_q) begin
      held_alone_s = dn_sync2_q & ~up_sync2_q;
    end else begin
      held_alone_s = up_sync2_q & ~dn_sync2_q;
    end
  end

  // Room left toward the latched direction, clamped step and resulting target.
  always_comb begin
    sum_s  = y_w_s + BAR_H_W;
    room_s = 10'd0;
    if (dir_q) begin
      if (sum_s >= Y_MAX_W) begin
        room_s = 10'd0;
      end else begin
        room_s = Y_MAX_W - sum_s;
      end
    end else begin
      if (y_w_s <= Y_MIN_W) begin
        room_s = 10'd0;
      end else begin
        room_s = y_w_s - Y_MIN_W;
      end
    end
    if (room_s < STEP_W) begin
      step_s = room_s[8:0];
    end else begin
      step_s = STEP_9;
    end
    if (dir_q) begin
      target_s = y_w_s + {1'b0, step_s};
    end else begin
      target_s = y_w_s - {1'b0, step_s};
    end
  end

  // Main control FSM with registered command outputs and busy flag.
  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      target_q  <= 10'd0;
      clk_en_q  <= 1'b0;
      refresh_q <= 1'b0;
      incdec_q  <= 1'b0;
      coordy_q  <= 9'd0;
      busy_q    <= 1'b0;
    end else if (!enablePong) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_en_q  <= 1'b0;
      refresh_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // Strobes are high only while in ISSUE; CHECK raises them below.
      clk_en_q  <= 1'b0;
      refresh_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (up_sync2_q ^ dn_sync2_q) begin
            dir_q   <= dn_sync2_q;
            cnt_q   <= '0;
            state_q <= DEBOUNCE;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        DEBOUNCE: begin
          if (!held_alone_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= CHECK;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        CHECK: begin
          if (room_s == 10'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            target_q  <= target_s;
            clk_en_q  <= 1'b1;
            refresh_q <= 1'b1;
            incdec_q  <= dir_q;
            coordy_q  <= step_s;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          if ((y_w_s == target_q) || (cnt_q == SET_LAST)) begin
            if (held_alone_s) begin
              state_q <= CHECK;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clk_en     = clk_en_q;
  assign refreshBar = refresh_q;
  assign incDec     = incdec_q;
  assign coordY     = coordy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bar_command_gen.sv
// Self-checking bench for bar_command_gen with short debounce/settle windows.
module tb_bar_command_gen;

  localparam int D     = 4;
  localparam int S     = 16;
  localparam int STEP  = 10;
  localparam int Y_MIN = 6;
  localparam int Y_MAX = 472;
  localparam int BAR_H = 89;

  logic       clk_in = 1'b0;
  logic       i_rst;
  logic       enablePong;
  logic       btn_up;
  logic       btn_down;
  logic [8:0] y_Atual;
  logic       clk_en;
  logic       refreshBar;
  logic       incDec;
  logic [8:0] coordY;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Observation results of the most recent watch() call.
  int         w_first;
  int         w_second;
  int         w_count;
  int         w_refresh_bad;
  logic [8:0] w_cy;
  logic       w_dir;
  logic       w_busy;

  bar_command_gen #(
    .DEBOUNCE_CYCLES(D),
    .SETTLE_CYCLES  (S),
    .STEP           (STEP),
    .Y_MIN          (Y_MIN),
    .Y_MAX          (Y_MAX),
    .BAR_H          (BAR_H)
  ) dut (
    .clk_in    (clk_in),
    .i_rst     (i_rst),
    .enablePong(enablePong),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .y_Atual   (y_Atual),
    .clk_en    (clk_en),
    .refreshBar(refreshBar),
    .incDec    (incDec),
    .coordY    (coordY),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  // Expected move size: room toward the direction, never beyond STEP.
  function automatic int model_step(input bit down, input int y);
    int room;
    if (down) room = Y_MAX - (y + BAR_H);
    else      room = y - Y_MIN;
    if (room < 0) room = 0;
    return (room < STEP) ? room : STEP;
  endfunction

  // Observe n falling edges and record strobe activity (indices are 1-based).
  task automatic watch(input int n);
    w_first = 0; w_second = 0; w_count = 0; w_refresh_bad = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_in);
      if (refreshBar !== clk_en) w_refresh_bad++;
      if (clk_en === 1'b1) begin
        w_count++;
        if (w_count == 1) begin
          w_first = i; w_cy = coordY; w_dir = incDec; w_busy = busy;
        end else if (w_count == 2) begin
          w_second = i;
        end
      end
    end
  endtask

  task automatic go_idle();
    btn_up = 1'b0; btn_down = 1'b0; enablePong = 1'b1;
    watch(S + 10);
  endtask

  task automatic test_reset();
    i_rst = 1'b0; enablePong = 1'b1; btn_down = 1'b1; btn_up = 1'b0; y_Atual = 9'd195;
    watch(3);
    n_checks++; if (clk_en !== 1'b0) $display("FAIL reset_clk_en got %b exp 0", clk_en); else n_pass++;
    n_checks++; if (refreshBar !== 1'b0) $display("FAIL reset_refreshBar got %b exp 0", refreshBar); else n_pass++;
    n_checks++; if (incDec !== 1'b0) $display("FAIL reset_incDec got %b exp 0", incDec); else n_pass++;
    n_checks++; if (coordY !== 9'd0) $display("FAIL reset_coordY got %0d exp 0", coordY); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    btn_down = 1'b0;
    i_rst = 1'b1;
    watch(4);
  endtask

  task automatic test_single_move();
    bit dirs[10];
    int ys[10];
    int e;
    dirs[0] = 1'b1; ys[0] = 195;
    dirs[1] = 1'b1; ys[1] = 377;
    dirs[2] = 1'b1; ys[2] = 383;
    dirs[3] = 1'b0; ys[3] = 10;
    for (int k = 4; k < 10; k++) begin
      dirs[k] = 1'($urandom_range(0, 1));
      ys[k]   = int'($urandom_range(0, 400));
    end
    for (int k = 0; k < 10; k++) begin
      e = model_step(dirs[k], ys[k]);
      y_Atual = 9'(ys[k]);
      btn_down = dirs[k]; btn_up = ~dirs[k];
      watch(D + 6);
      if (e > 0) begin
        n_checks++; if (w_count !== 1) $display("FAIL single_count y=%0d d=%0d got %0d exp 1", ys[k], dirs[k], w_count); else n_pass++;
        n_checks++; if (w_first !== D + 4) $display("FAIL single_latency y=%0d got %0d exp %0d", ys[k], w_first, D + 4); else n_pass++;
        n_checks++; if (w_cy !== 9'(e)) $display("FAIL single_coordY y=%0d d=%0d got %0d exp %0d", ys[k], dirs[k], w_cy, e); else n_pass++;
        n_checks++; if (w_dir !== dirs[k]) $display("FAIL single_incDec y=%0d got %b exp %b", ys[k], w_dir, dirs[k]); else n_pass++;
        n_checks++; if (w_busy !== 1'b1) $display("FAIL single_busy y=%0d got %b exp 1", ys[k], w_busy); else n_pass++;
      end else begin
        n_checks++; if (w_count !== 0) $display("FAIL clamp_no_pulse y=%0d d=%0d got %0d exp 0", ys[k], dirs[k], w_count); else n_pass++;
      end
      n_checks++; if (w_refresh_bad !== 0) $display("FAIL single_refresh_eq y=%0d got %0d exp 0", ys[k], w_refresh_bad); else n_pass++;
      btn_down = 1'b0; btn_up = 1'b0;
      watch(S + 6);
      n_checks++; if (w_count !== 0) $display("FAIL single_after_release y=%0d got %0d exp 0", ys[k], w_count); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy y=%0d got %b exp 0", ys[k], busy); else n_pass++;
      if (e > 0) begin
        n_checks++; if (coordY !== 9'(e)) $display("FAIL hold_coordY y=%0d got %0d exp %0d", ys[k], coordY, e); else n_pass++;
        n_checks++; if (incDec !== dirs[k]) $display("FAIL hold_incDec y=%0d got %b exp %b", ys[k], incDec, dirs[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_repeat_timeout();
    bit d;
    int y;
    d = 1'($urandom_range(0, 1));
    y = int'($urandom_range(20, 300));
    y_Atual = 9'(y);
    btn_down = d; btn_up = ~d;
    watch(D + 6 + 2 * (S + 2));
    n_checks++; if (w_count !== 3) $display("FAIL repeat_count y=%0d got %0d exp 3", y, w_count); else n_pass++;
    n_checks++; if (w_second !== D + 4 + S + 2) $display("FAIL settle_timeout got %0d exp %0d", w_second, D + 4 + S + 2); else n_pass++;
    go_idle();
  endtask

  task automatic test_glitch();
    int total;
    y_Atual = 9'd195;
    for (int k = 1; k <= D + 1; k++) begin
      btn_down = 1'b1;
      watch(k);
      total = w_count;
      btn_down = 1'b0;
      watch(S + 10);
      total += w_count;
      n_checks++; if (total !== ((k == D + 1) ? 1 : 0)) $display("FAIL glitch_len%0d got %0d exp %0d", k, total, (k == D + 1) ? 1 : 0); else n_pass++;
    end
    total = 0;
    for (int t = 0; t < 12; t++) begin
      btn_down = ~btn_down;
      watch(2);
      total += w_count;
    end
    btn_down = 1'b0;
    watch(10);
    total += w_count;
    n_checks++; if (total !== 0) $display("FAIL toggle_no_pulse got %0d exp 0", total); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL toggle_busy got %b exp 0", busy); else n_pass++;
    btn_down = 1'b1; btn_up = 1'b1;
    watch(30);
    n_checks++; if (w_count !== 0) $display("FAIL both_no_pulse got %0d exp 0", w_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL both_busy got %b exp 0", busy); else n_pass++;
    go_idle();
  endtask

  task automatic test_settle_update();
    int m;
    y_Atual = 9'd195; btn_down = 1'b1; btn_up = 1'b0;
    watch(D + 4);
    n_checks++; if (w_first !== D + 4) $display("FAIL upd_first got %0d exp %0d", w_first, D + 4); else n_pass++;
    m = int'($urandom_range(1, 12));
    watch(m);
    n_checks++; if (w_count !== 0 || busy !== 1'b1) $display("FAIL upd_settle_wait cnt=%0d busy=%b exp 0/1", w_count, busy); else n_pass++;
    y_Atual = 9'd205;
    watch(3);
    n_checks++; if (w_first !== 2) $display("FAIL upd_second_latency m=%0d got %0d exp 2", m, w_first); else n_pass++;
    n_checks++; if (w_cy !== 9'd10 || w_dir !== 1'b1) $display("FAIL upd_second_cmd got %0d/%b exp 10/1", w_cy, w_dir); else n_pass++;
    go_idle();
    y_Atual = 9'd195; btn_down = 1'b1;
    watch(D + 4);
    btn_down = 1'b0;
    watch(5);
    y_Atual = 9'd205;
    watch(2);
    n_checks++; if (w_count !== 0) $display("FAIL upd_release_pulse got %0d exp 0", w_count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL upd_release_busy got %b exp 0", busy); else n_pass++;
    go_idle();
  endtask

  task automatic test_enable_abort();
    int m;
    int total;
    y_Atual = 9'd195; btn_down = 1'b1; btn_up = 1'b0;
    watch(D + 4);
    m = int'($urandom_range(1, 10));
    watch(m);
    enablePong = 1'b0;
    watch(1);
    n_checks++; if (busy !== 1'b0) $display("FAIL en_abort_busy m=%0d got %b exp 0", m, busy); else n_pass++;
    watch(30);
    n_checks++; if (w_count !== 0 || busy !== 1'b0) $display("FAIL en_off_idle cnt=%0d busy=%b exp 0/0", w_count, busy); else n_pass++;
    enablePong = 1'b1;
    watch(D + 4);
    n_checks++; if (w_first !== D + 2 || w_count !== 1) $display("FAIL en_resume got %0d/%0d exp %0d/1", w_first, w_count, D + 2); else n_pass++;
    go_idle();
    m = int'($urandom_range(1, D + 3));
    btn_down = 1'b1;
    watch(m);
    total = w_count;
    enablePong = 1'b0;
    watch(30);
    total += w_count;
    n_checks++; if (total !== 0) $display("FAIL en_early_drop j=%0d got %0d exp 0", m, total); else n_pass++;
    go_idle();
  endtask

  task automatic test_reset_abort();
    y_Atual = 9'd195; btn_down = 1'b1; btn_up = 1'b0;
    watch(D + 4);
    n_checks++; if (w_first !== D + 4) $display("FAIL rst_pre_pulse got %0d exp %0d", w_first, D + 4); else n_pass++;
    #1 i_rst = 1'b0;
    #1;
    n_checks++; if ({clk_en, refreshBar, incDec, coordY, busy} !== 13'd0)
      $display("FAIL rst_async_outputs got %b%b%b %0d %b exp all 0", clk_en, refreshBar, incDec, coordY, busy); else n_pass++;
    @(negedge clk_in);
    btn_down = 1'b0;
    watch(3);
    i_rst = 1'b1;
    watch(30);
    n_checks++; if (w_count !== 0 || busy !== 1'b0) $display("FAIL rst_no_repeat cnt=%0d busy=%b exp 0/0", w_count, busy); else n_pass++;
    btn_down = 1'b1;
    watch(D + 6);
    n_checks++; if (w_first !== D + 4 || w_count !== 1) $display("FAIL rst_resume got %0d/%0d exp %0d/1", w_first, w_count, D + 4); else n_pass++;
    go_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b0; enablePong = 1'b1; btn_up = 1'b0; btn_down = 1'b0; y_Atual = 9'd0;
    test_reset();
    test_single_move();
    test_repeat_timeout();
    test_glitch();
    test_settle_update();
    test_enable_abort();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
